// File: rtl/f_sched_pkg.sv
// Shared tables for the BLAKE2 round scheduler: message permutation (SIGMA)
// and the column/diagonal state-word indices of the eight G calls (GIDX).
package f_sched_pkg;

  typedef logic [3:0] sel_t;

  localparam int ROUNDS_S = 10;
  localparam int ROUNDS_B = 12;

  localparam sel_t SIGMA [10][16] = '{
    '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'ha, 4'hb, 4'hc, 4'hd, 4'he, 4'hf},
    '{4'he, 4'ha, 4'h4, 4'h8, 4'h9, 4'hf, 4'hd, 4'h6, 4'h1, 4'hc, 4'h0, 4'h2, 4'hb, 4'h7, 4'h5, 4'h3},
    '{4'hb, 4'h8, 4'hc, 4'h0, 4'h5, 4'h2, 4'hf, 4'hd, 4'ha, 4'he, 4'h3, 4'h6, 4'h7, 4'h1, 4'h9, 4'h4},
    '{4'h7, 4'h9, 4'h3, 4'h1, 4'hd, 4'hc, 4'hb, 4'he, 4'h2, 4'h6, 4'h5, 4'ha, 4'h4, 4'h0, 4'hf, 4'h8},
    '{4'h9, 4'h0, 4'h5, 4'h7, 4'h2, 4'h4, 4'ha, 4'hf, 4'he, 4'h1, 4'hb, 4'hc, 4'h6, 4'h8, 4'h3, 4'hd},
    '{4'h2, 4'hc, 4'h6, 4'ha, 4'h0, 4'hb, 4'h8, 4'h3, 4'h4, 4'hd, 4'h7, 4'h5, 4'hf, 4'he, 4'h1, 4'h9},
    '{4'hc, 4'h5, 4'h1, 4'hf, 4'he, 4'hd, 4'h4, 4'ha, 4'h0, 4'h7, 4'h6, 4'h3, 4'h9, 4'h2, 4'h8, 4'hb},
    '{4'hd, 4'hb, 4'h7, 4'he, 4'hc, 4'h1, 4'h3, 4'h9, 4'h5, 4'h0, 4'hf, 4'h4, 4'h8, 4'h6, 4'h2, 4'ha},
    '{4'h6, 4'hf, 4'he, 4'h9, 4'hb, 4'h3, 4'h0, 4'h8, 4'hc, 4'h2, 4'hd, 4'h7, 4'h1, 4'h4, 4'ha, 4'h5},
    '{4'ha, 4'h2, 4'h8, 4'h4, 4'h7, 4'h6, 4'h1, 4'h5, 4'hf, 4'hb, 4'h9, 4'he, 4'h3, 4'hc, 4'hd, 4'h0}
  };

  // Rows 0-3 are the columns, rows 4-7 the diagonals; entries are a, b, c, d.
  localparam sel_t GIDX [8][4] = '{
    '{4'h0, 4'h4, 4'h8, 4'hc},
    '{4'h1, 4'h5, 4'h9, 4'hd},
    '{4'h2, 4'h6, 4'ha, 4'he},
    '{4'h3, 4'h7, 4'hb, 4'hf},
    '{4'h0, 4'h5, 4'ha, 4'hf},
    '{4'h1, 4'h6, 4'hb, 4'hc},
    '{4'h2, 4'h7, 4'h8, 4'hd},
    '{4'h3, 4'h4, 4'h9, 4'he}
  };

endpackage

// File: rtl/f_sched_lane.sv
// Combinational decode of one G call: state-word and message-word selects
// for a given sub index and round.
module f_sched_lane
  import f_sched_pkg::*;
(
  input  logic [2:0] sub,
  input  logic [3:0] rnd,
  output sel_t       a_sel,
  output sel_t       b_sel,
  output sel_t       c_sel,
  output sel_t       d_sel,
  output sel_t       m0_sel,
  output sel_t       m1_sel
);

  logic [3:0] row;

  always_comb begin
    // BLAKE2b rounds 10 and 11 wrap back onto permutation rows 0 and 1.
    row    = (rnd >= 4'd10) ? (rnd - 4'd10) : rnd;
    a_sel  = GIDX[sub][0];
    b_sel  = GIDX[sub][1];
    c_sel  = GIDX[sub][2];
    d_sel  = GIDX[sub][3];
    m0_sel = SIGMA[row][{sub, 1'b0}];
    m1_sel = SIGMA[row][{sub, 1'b1}];
  end

endmodule

// File: rtl/f_sched_seq.sv
// BLAKE2 compression-round scheduler: walks rounds and beats, issuing LANES
// G-call select sets per beat over a valid/ready handshake.
module f_sched_seq
  import f_sched_pkg::*;
#(
  parameter int NUM_ROUNDS = 10,
  parameter int LANES      = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               out_ready,
  output logic               out_valid,
  output logic               out_last,
  output logic [3:0]         out_rnd,
  output logic [2:0]         out_sub,
  output logic [4*LANES-1:0] a_sel,
  output logic [4*LANES-1:0] b_sel,
  output logic [4*LANES-1:0] c_sel,
  output logic [4*LANES-1:0] d_sel,
  output logic [4*LANES-1:0] m0_sel,
  output logic [4*LANES-1:0] m1_sel,
  output logic               busy,
  output logic               done
);

  localparam int BPR = 8 / LANES;
  localparam logic [3:0] LAST_RND  = 4'(NUM_ROUNDS - 1);
  localparam logic [2:0] LAST_BEAT = 3'(BPR - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  if (!(NUM_ROUNDS == ROUNDS_S || NUM_ROUNDS == ROUNDS_B)) begin : g_bad_rounds
    $error("f_sched_seq: NUM_ROUNDS must be 10 or 12");
  end
  if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
    $error("f_sched_seq: LANES must be 1, 2 or 4");
  end

  logic [0:0] state_q, state_d;
  logic [3:0] rnd_q, rnd_d;
  logic [2:0] beat_q, beat_d;
  logic       done_q, done_d;
  logic       run, is_last;

  assign run     = (state_q == ST_RUN);
  assign is_last = run && (rnd_q == LAST_RND) && (beat_q == LAST_BEAT);

  // Counters are cleared whenever we drop to IDLE so idle outputs decode to zero.
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    beat_d  = beat_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_RUN;
          rnd_d   = '0;
          beat_d  = '0;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
          rnd_d   = '0;
          beat_d  = '0;
        end else if (out_ready) begin
          if (is_last) begin
            state_d = ST_IDLE;
            rnd_d   = '0;
            beat_d  = '0;
            done_d  = 1'b1;
          end else if (beat_q == LAST_BEAT) begin
            beat_d = '0;
            rnd_d  = rnd_q + 4'd1;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rnd_q   <= '0;
      beat_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      beat_q  <= beat_d;
      done_q  <= done_d;
    end
  end

  logic [2:0] lane_sub [LANES];
  sel_t lane_a [LANES];
  sel_t lane_b [LANES];
  sel_t lane_c [LANES];
  sel_t lane_d [LANES];
  sel_t lane_m0[LANES];
  sel_t lane_m1[LANES];

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign lane_sub[k] = 3'(int'(beat_q) * LANES + k);

    f_sched_lane u_lane (
      .sub    (lane_sub[k]),
      .rnd    (rnd_q),
      .a_sel  (lane_a[k]),
      .b_sel  (lane_b[k]),
      .c_sel  (lane_c[k]),
      .d_sel  (lane_d[k]),
      .m0_sel (lane_m0[k]),
      .m1_sel (lane_m1[k])
    );
  end

  always_comb begin
    out_valid = run;
    busy      = run;
    out_last  = is_last;
    done      = done_q;
    out_rnd   = rnd_q;
    out_sub   = 3'(int'(beat_q) * LANES);
    a_sel     = '0;
    b_sel     = '0;
    c_sel     = '0;
    d_sel     = '0;
    m0_sel    = '0;
    m1_sel    = '0;
    if (run) begin
      for (int k = 0; k < LANES; k++) begin
        a_sel[4*k +: 4]  = lane_a[k];
        b_sel[4*k +: 4]  = lane_b[k];
        c_sel[4*k +: 4]  = lane_c[k];
        d_sel[4*k +: 4]  = lane_d[k];
        m0_sel[4*k +: 4] = lane_m0[k];
        m1_sel[4*k +: 4] = lane_m1[k];
      end
    end
  end

endmodule

// File: tb/tb_f_sched_seq.sv
// Directed bench for f_sched_seq: three instances cover BLAKE2s/1 lane,
// BLAKE2b/1 lane and BLAKE2s/4 lanes against hand-computed select values.
module tb_f_sched_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start_i [3];
  logic       abort_i [3];
  logic       ready_i [3];
  logic       valid_w [3];
  logic       last_w  [3];
  logic       busy_w  [3];
  logic       done_w  [3];
  logic [3:0] rnd_w   [3];
  logic [2:0] sub_w   [3];
  logic [3:0] sel1_w  [2][6];
  logic [15:0] sel4_w [6];

  typedef struct packed {
    logic [20:0] pad;
    logic        valid;
    logic        last;
    logic        busy;
    logic        done;
    logic [3:0]  rnd;
    logic [2:0]  sub;
    logic [15:0] a, b, c, d, m0, m1;
  } obs_t;

  obs_t obs [3];

  int nChecks = 0;
  int nPass   = 0;

  f_sched_seq #(.NUM_ROUNDS(10), .LANES(1)) u_dut_s1 (
    .clk(clk), .rst(rst), .start(start_i[0]), .abort(abort_i[0]), .out_ready(ready_i[0]),
    .out_valid(valid_w[0]), .out_last(last_w[0]), .out_rnd(rnd_w[0]), .out_sub(sub_w[0]),
    .a_sel(sel1_w[0][0]), .b_sel(sel1_w[0][1]), .c_sel(sel1_w[0][2]), .d_sel(sel1_w[0][3]),
    .m0_sel(sel1_w[0][4]), .m1_sel(sel1_w[0][5]), .busy(busy_w[0]), .done(done_w[0])
  );

  f_sched_seq #(.NUM_ROUNDS(12), .LANES(1)) u_dut_b1 (
    .clk(clk), .rst(rst), .start(start_i[1]), .abort(abort_i[1]), .out_ready(ready_i[1]),
    .out_valid(valid_w[1]), .out_last(last_w[1]), .out_rnd(rnd_w[1]), .out_sub(sub_w[1]),
    .a_sel(sel1_w[1][0]), .b_sel(sel1_w[1][1]), .c_sel(sel1_w[1][2]), .d_sel(sel1_w[1][3]),
    .m0_sel(sel1_w[1][4]), .m1_sel(sel1_w[1][5]), .busy(busy_w[1]), .done(done_w[1])
  );

  f_sched_seq #(.NUM_ROUNDS(10), .LANES(4)) u_dut_s4 (
    .clk(clk), .rst(rst), .start(start_i[2]), .abort(abort_i[2]), .out_ready(ready_i[2]),
    .out_valid(valid_w[2]), .out_last(last_w[2]), .out_rnd(rnd_w[2]), .out_sub(sub_w[2]),
    .a_sel(sel4_w[0]), .b_sel(sel4_w[1]), .c_sel(sel4_w[2]), .d_sel(sel4_w[3]),
    .m0_sel(sel4_w[4]), .m1_sel(sel4_w[5]), .busy(busy_w[2]), .done(done_w[2])
  );

  // Gather each instance's outputs into one comparable record.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      obs[i]       = '0;
      obs[i].valid = valid_w[i];
      obs[i].last  = last_w[i];
      obs[i].busy  = busy_w[i];
      obs[i].done  = done_w[i];
      obs[i].rnd   = rnd_w[i];
      obs[i].sub   = sub_w[i];
    end
    for (int i = 0; i < 2; i++) begin
      obs[i].a  = {12'h000, sel1_w[i][0]};
      obs[i].b  = {12'h000, sel1_w[i][1]};
      obs[i].c  = {12'h000, sel1_w[i][2]};
      obs[i].d  = {12'h000, sel1_w[i][3]};
      obs[i].m0 = {12'h000, sel1_w[i][4]};
      obs[i].m1 = {12'h000, sel1_w[i][5]};
    end
    obs[2].a  = sel4_w[0];
    obs[2].b  = sel4_w[1];
    obs[2].c  = sel4_w[2];
    obs[2].d  = sel4_w[3];
    obs[2].m0 = sel4_w[4];
    obs[2].m1 = sel4_w[5];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] want);
    nChecks++;
    if (got === want) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
  endtask

  task automatic applyStimulus(input int d, input logic st, input logic ab, input logic rdy);
    start_i[d] = st;
    abort_i[d] = ab;
    ready_i[d] = rdy;
  endtask

  task automatic checkSels(input int d, input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                           input logic [15:0] dd, input logic [15:0] m0, input logic [15:0] m1);
    checkOutput("a_sel", 128'(obs[d].a), 128'(a));
    checkOutput("b_sel", 128'(obs[d].b), 128'(b));
    checkOutput("c_sel", 128'(obs[d].c), 128'(c));
    checkOutput("d_sel", 128'(obs[d].d), 128'(dd));
    checkOutput("m0_sel", 128'(obs[d].m0), 128'(m0));
    checkOutput("m1_sel", 128'(obs[d].m1), 128'(m1));
  endtask

  // Hand-computed select values at selected beats of each configuration.
  task automatic spotCheck(input int d, input int r, input int b);
    case (d)
      0: begin
        if (r == 0 && b == 0) checkSels(d, 16'h0, 16'h4, 16'h8, 16'hc, 16'h0, 16'h1);
        if (r == 0 && b == 5) checkSels(d, 16'h1, 16'h6, 16'hb, 16'hc, 16'ha, 16'hb);
        if (r == 1 && b == 0) begin
          checkOutput("r1s0_m0", 128'(obs[d].m0), 128'(16'he));
          checkOutput("r1s0_m1", 128'(obs[d].m1), 128'(16'ha));
        end
        if (r == 9 && b == 7) begin
          checkOutput("r9s7_m0", 128'(obs[d].m0), 128'(16'hd));
          checkOutput("r9s7_m1", 128'(obs[d].m1), 128'(16'h0));
        end
      end
      1: begin
        if (r == 10 && b == 0) begin
          checkOutput("r10s0_m0", 128'(obs[d].m0), 128'(16'h0));
          checkOutput("r10s0_m1", 128'(obs[d].m1), 128'(16'h1));
        end
        if (r == 11 && b == 7) checkSels(d, 16'h3, 16'h4, 16'h9, 16'he, 16'h5, 16'h3);
      end
      default: begin
        if (r == 0 && b == 0) checkSels(d, 16'h3210, 16'h7654, 16'hba98, 16'hfedc, 16'h6420, 16'h7531);
        if (r == 0 && b == 1) begin
          checkOutput("l4b1_b", 128'(obs[d].b), 128'(16'h4765));
          checkOutput("l4b1_d", 128'(obs[d].d), 128'(16'hedcf));
        end
      end
    endcase
  endtask

  task automatic checkBeat(input int d, input int r, input int b, input int lanes, input int nr);
    checkOutput("valid", 128'(obs[d].valid), 128'(1));
    checkOutput("busy", 128'(obs[d].busy), 128'(1));
    checkOutput("rnd", 128'(obs[d].rnd), 128'(r));
    checkOutput("sub", 128'(obs[d].sub), 128'(b * lanes));
    checkOutput("last", 128'(obs[d].last), 128'((r == nr - 1) && (b == 8 / lanes - 1)));
  endtask

  // Full schedule with ready high, optional 3-cycle stall, optional restart in the done cycle.
  task automatic runSchedule(input int d, input int nr, input int lanes, input int stallAt, input bit restartOnDone);
    int bpr, total, beats, expRnd, expBeat;
    bit gotDone;
    obs_t snap;
    bpr = 8 / lanes;
    total = nr * bpr;
    beats = 0;
    expRnd = 0;
    expBeat = 0;
    gotDone = 0;
    applyStimulus(d, 1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(d, 1'b0, 1'b0, 1'b1);
    for (int cyc = 0; cyc < total + 20 && !gotDone; cyc++) begin
      if (obs[d].done) begin
        gotDone = 1;
        checkOutput("done_beat_count", 128'(beats), 128'(total));
        checkOutput("done_valid_low", 128'(obs[d].valid), 128'(0));
      end else if (!obs[d].valid) begin
        checkOutput("valid_dropped", 128'(obs[d].valid), 128'(1));
        break;
      end else begin
        checkBeat(d, expRnd, expBeat, lanes, nr);
        spotCheck(d, expRnd, expBeat);
        if (beats == stallAt) begin
          snap = obs[d];
          applyStimulus(d, 1'b0, 1'b0, 1'b0);
          repeat (3) begin
            tick();
            checkOutput("stall_hold", obs[d], snap);
          end
          applyStimulus(d, 1'b0, 1'b0, 1'b1);
        end
        beats++;
        expBeat++;
        if (expBeat == bpr) begin
          expBeat = 0;
          expRnd++;
        end
        tick();
      end
    end
    if (!gotDone) checkOutput("done_timeout", 128'(gotDone), 128'(1));
    else begin
      if (restartOnDone) applyStimulus(d, 1'b1, 1'b0, 1'b1);
      tick();
      applyStimulus(d, 1'b0, 1'b0, 1'b1);
      checkOutput("done_one_cycle", 128'(obs[d].done), 128'(0));
      if (restartOnDone) begin
        checkOutput("restart_valid", 128'(obs[d].valid), 128'(1));
        checkOutput("restart_rnd", 128'(obs[d].rnd), 128'(0));
        checkOutput("restart_sub", 128'(obs[d].sub), 128'(0));
        applyStimulus(d, 1'b0, 1'b1, 1'b1);
        tick();
        applyStimulus(d, 1'b0, 1'b0, 1'b1);
        checkOutput("restart_abort_valid", 128'(obs[d].valid), 128'(0));
      end else begin
        checkOutput("post_done_valid", 128'(obs[d].valid), 128'(0));
        checkOutput("post_done_busy", 128'(obs[d].busy), 128'(0));
      end
    end
  endtask

  // Start and advance n beats (optionally pulsing start mid-run), leaving beat n showing.
  task automatic runUntil(input int d, input int lanes, input int nr, input int n, input int startAt);
    int expRnd, expBeat;
    expRnd = 0;
    expBeat = 0;
    applyStimulus(d, 1'b1, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < n; i++) begin
      checkBeat(d, expRnd, expBeat, lanes, nr);
      applyStimulus(d, (i == startAt), 1'b0, 1'b1);
      tick();
      expBeat++;
      if (expBeat == 8 / lanes) begin
        expBeat = 0;
        expRnd++;
      end
    end
    applyStimulus(d, 1'b0, 1'b0, 1'b1);
    checkBeat(d, expRnd, expBeat, lanes, nr);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(i, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    for (int i = 0; i < 3; i++) checkOutput("reset_zero", obs[i], '0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) checkOutput("idle_zero", obs[i], '0);

    $display("[TB] abort in IDLE blocks start");
    applyStimulus(0, 1'b1, 1'b1, 1'b1);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 1'b1);
    checkOutput("idle_abort_valid", 128'(obs[0].valid), 128'(0));

    $display("[TB] BLAKE2s, 1 lane, stall at beat 5");
    runSchedule(0, 10, 1, 5, 1'b0);

    $display("[TB] BLAKE2b, 1 lane");
    runSchedule(1, 12, 1, -1, 1'b0);

    $display("[TB] BLAKE2s, 4 lanes, restart in done cycle");
    runSchedule(2, 10, 4, -1, 1'b1);

    $display("[TB] abort at beat 20 with start pulsed mid-run");
    runUntil(0, 1, 10, 20, 10);
    applyStimulus(0, 1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 1'b1);
    checkOutput("abort_valid", 128'(obs[0].valid), 128'(0));
    checkOutput("abort_busy", 128'(obs[0].busy), 128'(0));
    checkOutput("abort_rnd", 128'(obs[0].rnd), 128'(0));
    repeat (3) begin
      checkOutput("abort_no_done", 128'(obs[0].done), 128'(0));
      tick();
    end
    runSchedule(0, 10, 1, -1, 1'b0);

    $display("[TB] abort on final beat suppresses done");
    runUntil(0, 1, 10, 79, -1);
    applyStimulus(0, 1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 1'b1);
    checkOutput("abort_last_done", 128'(obs[0].done), 128'(0));
    checkOutput("abort_last_valid", 128'(obs[0].valid), 128'(0));

    $display("[TB] reset at beat 30");
    runUntil(0, 1, 10, 30, -1);
    rst = 1'b1;
    tick();
    checkOutput("midrun_reset_zero", obs[0], '0);
    rst = 1'b0;
    tick();
    runSchedule(0, 10, 1, -1, 1'b0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/f_sched_seq.md
Name: f_sched_seq

Overview:
Sequential BLAKE2 compression-round scheduler. It walks the round and G-function (sub) counters itself and emits, per beat, the state-word selects (a/b/c/d) and message-word selects (m0/m1) for LANES G-functions in parallel. It uses a valid/ready handshake toward the G datapath. NUM_ROUNDS selects the BLAKE2s (10) or BLAKE2b (12) round count. It sits between the compression controller (start/done) and the G-function datapath.

Parameters:
NUM_ROUNDS, 10, rounds per compression; legal values 10 or 12 only (elaboration error otherwise).
LANES, 1, G-functions issued per beat; legal values 1, 2, 4. Beats per round BPR = 8/LANES.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin a compression schedule; sampled only in IDLE
abort  in  1  cancel the schedule in progress
out_ready  in  1  datapath accepts the current beat
out_valid  out  1  beat outputs are valid
out_last  out  1  current beat is the final beat of the final round
out_rnd  out  4  round index of the current beat
out_sub  out  3  sub index of lane 0 of the current beat
a_sel, b_sel, c_sel, d_sel  out  4*LANES each  state-word selects; lane k occupies bits [4k+3:4k]
m0_sel, m1_sel  out  4*LANES each  message-word selects, same packing
busy  out  1  state is RUN
done  out  1  one-cycle pulse after the final beat is accepted

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE, counters 0. All outputs are 0: out_valid, out_last, out_rnd, out_sub, every select, busy, done. This applies at any time, including mid-schedule.
- States: IDLE and RUN.
- IDLE -> RUN: when start=1 and abort=0. On the next cycle, out_valid=1, busy=1, rnd=0, beat=0 (latency 1). start in RUN is ignored.
- RUN: out_valid=1 every cycle. A beat advances only when out_valid && out_ready.
  - With out_ready=0, every output holds exactly its value.
  - beat counts 0..BPR-1. On wrap, rnd increments. out_sub = beat*LANES.
- Lane k of a beat handles sub s = beat*LANES + k:
  - s = 0..3 (columns): a=s, b=4+s, c=8+s, d=12+s.
  - s = 4..7 (diagonals): (0,5,10,15), (1,6,11,12), (2,7,8,13), (3,4,9,14).
  - m0 = SIGMA[rnd mod 10][2s], m1 = SIGMA[rnd mod 10][2s+1]. Rounds 10 and 11 therefore reuse SIGMA rows 0 and 1.
- out_last=1 only when rnd = NUM_ROUNDS-1 and beat = BPR-1.
- Final handshake (out_last && out_ready) -> IDLE next cycle, with done=1 for exactly that one cycle.
  - start may be asserted in that done cycle; it is accepted normally.
- abort=1 in RUN -> IDLE next cycle; done stays 0; no further beats issue. abort has priority over a simultaneous final handshake: done is suppressed.
- abort=1 in IDLE is a no-op and blocks a coincident start.
- In IDLE, every select, out_rnd and out_sub is driven 0, never X.
- All outputs are registered or decoded only from registered state. There is no combinational path from out_ready to out_valid.

Decomposition:
- Package f_sched_pkg holds:
  - SIGMA: localparam 10x16 array of 4-bit values.
  - GIDX: localparam 8x4 a/b/c/d index table.
  - typedef sel_t = logic [3:0].
  - Constants: ROUNDS_S = 10, ROUNDS_B = 12.
- One combinational sub-module, f_sched_lane (inputs sub, rnd; outputs the six sel_t values), instantiated LANES times from a generate loop. The FSM and counters live in f_sched_seq.

Test Plan:
- LANES=1, NUM_ROUNDS=10, out_ready=1, pulse start -> first beat a,b,c,d,m0,m1 = 0,4,8,c,0,1. Beat 8 (rnd1 sub0) has m0=e, m1=a. 80 beats total. Last beat is rnd9 sub7 with m0=d, m1=0 and out_last=1. done pulses exactly one cycle later.
- LANES=1, NUM_ROUNDS=12 -> 96 beats. rnd10 sub0 gives m0=0, m1=1. rnd11 sub7 gives a,b,c,d = 3,4,9,e and m0,m1 = 5,3.
- LANES=4, NUM_ROUNDS=10 -> 20 beats.
  - Beat 0: a lanes = 0,1,2,3; m0/m1 pairs (0,1),(2,3),(4,5),(6,7).
  - Beat 1: b lanes = 5,6,7,4; d lanes = f,c,d,e.
- Backpressure: hold out_ready=0 for 3 cycles at beat 5 -> all outputs stable across those cycles. No beat is skipped or duplicated in the total count of 80.
- Abort at beat 20 -> out_valid=0 and busy=0 the next cycle, done never asserts. A following start restarts at rnd0 sub0. start pulsed during RUN is ignored.
- Assert rst at beat 30 -> every output reads 0 the next cycle. A subsequent start produces the full 80-beat sequence from rnd0 sub0.
